amo_arbiter: RTL and testbench
==============================

# amo_arbiter

Two-port atomic memory operation (AMO) sequencer and arbiter for the dual-core system. It accepts AMO requests from core 0 and core 1 and grants one at a time in round-robin order. For the granted request it runs a locked read-modify-write on the shared data-memory port, using a single shared `amo_alu` instance, and returns the original memory value to the requesting core. Only one AMO is in flight at a time, which keeps each read-modify-write atomic with respect to both cores.

## Interface
- No parameters; data width is fixed at 32 and the requester count at 2.
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `req_valid`  in  2  per-core AMO request valid, index = core ID
- `req_ready`  out  2  per-core accept strobe; one-hot or zero
- `req_addr`  in  2x32  per-core word address
- `req_rs2`  in  2x32  per-core rs2 operand
- `req_op`  in  2x5  per-core AMO opcode, encoded with the `AMO_*` constants in `taiga_types`
- `resp_valid`  out  2  per-core response valid; one-hot or zero
- `resp_ready`  in  2  per-core response accept
- `resp_data`  out  32  original memory word for the response in progress
- `mem_req`  out  1  memory access request
- `mem_we`  out  1  1 = write, 0 = read
- `mem_addr`  out  32  memory word address
- `mem_wdata`  out  32  write data
- `mem_ack`  in  1  memory completes the current access this cycle
- `mem_rdata`  in  32  read data, valid when `mem_ack` is high on a read
- `mem_lock`  out  1  bus-lock hint to the memory arbiter, high for the whole read-modify-write

## Operation
- States: IDLE, RD, WR, RESP.
- **IDLE.** If any `req_valid` bit is set, grant one core:
  - If only one core requests, grant it.
  - If both request, grant the core that was not granted last.
  - `last_grant` resets to 1, so core 0 wins the first tie.
  - In the accept cycle, assert `req_ready[g]` combinationally. Latch `addr`, `rs2`, `op` and `g`; update `last_grant`; go to RD.
- **RD.**
  - Outputs: `mem_req`=1, `mem_we`=0, `mem_addr`=latched `addr`, `mem_lock`=1.
  - On `mem_ack`: register `mem_rdata` into `old_val`, register `amo_alu` result into `new_val`, go to WR.
  - `amo_alu` inputs: `rs1_load`=`mem_rdata`, `rs2`=latched `rs2`, `op`=latched `op`.
- **WR.**
  - Outputs: `mem_req`=1, `mem_we`=1, `mem_addr`=latched `addr`, `mem_wdata`=`new_val`, `mem_lock`=1.
  - On `mem_ack`, go to RESP.
- **RESP.** `resp_valid[g]`=1, `resp_data`=`old_val`, `mem_lock`=0. On `resp_ready[g]`, go to IDLE.
- ALU semantics:
  - MIN/MAX compare signed; MINU/MAXU compare unsigned; ADD wraps mod 2^32.
  - An undefined opcode writes 0. The response still returns `old_val`.
- Requests that arrive while the block is busy wait. `req_valid` must stay asserted until `req_ready`; `req_*` fields are sampled only in the accept cycle.

## Timing
- Reset values:
  - State IDLE, `last_grant`=1.
  - `req_ready`=0, `resp_valid`=0, `mem_req`=0, `mem_we`=0, `mem_lock`=0.
  - `mem_addr`, `mem_wdata`, `resp_data` = 0.
- All outputs except `req_ready` are decoded from registered state and registered data; there are no combinational paths from the memory inputs.
- Minimum latency with zero-wait memory (`mem_ack` in the first cycle of each access):
  - Accept at cycle T.
  - RD at T+1, WR at T+2.
  - `resp_valid` at T+3.
  - Next accept no earlier than T+4, one cycle after `resp_ready`.
- `mem_req`, `mem_we` and `mem_addr` stay stable while waiting for `mem_ack`.
- `mem_lock` rises with the RD `mem_req` and falls in the cycle after the WR ack.
- `mem_ack` is ignored in IDLE and RESP.
- `resp_valid` and `resp_data` hold stable until `resp_ready[g]`. `resp_ready` of the non-granted core is ignored.
- Asynchronous reset mid-operation:
  - All outputs return to reset values immediately.
  - The in-flight AMO is dropped without a response.
  - Memory is left either untouched or written, depending on whether the WR ack had occurred.

## Test plan
- **Single AMO_ADD.**
  - Setup: core 0 request, `addr`=0x100, `rs2`=5; memory returns 0x0000_000A; zero-wait memory.
  - Expected: read at 0x100, then write of 0x0F at 0x100; `resp_data`=0x0A on `resp_valid[0]` exactly 3 cycles after accept; `mem_lock` high for exactly 2 cycles.
- **Signed vs unsigned.**
  - Setup: memory=0xFFFF_FFFF, `rs2`=1.
  - Expected: AMO_MIN writes 0xFFFF_FFFF; AMO_MINU writes 1; AMO_MAX writes 1; AMO_MAXU writes 0xFFFF_FFFF.
- **Simultaneous requests from reset.**
  - Setup: both cores request in the same cycle and hold.
  - Expected: core 0 granted first, then core 1. A second pair of simultaneous requests after that is also served core 0 then core 1, confirming round-robin alternation.
- **Memory wait states.**
  - Setup: `mem_ack` delayed 3 cycles on the read and 2 on the write.
  - Expected: `mem_req`, `mem_addr` and `mem_wdata` stable throughout; `resp_valid` 8 cycles after accept.
- **Response backpressure.**
  - Setup: hold `resp_ready`=0 for 4 cycles while core 1 requests.
  - Expected: `resp_data` stable; core 1 not accepted until the cycle after the `resp_ready` handshake.
- **Reset mid-write.**
  - Setup: assert `rst_n`=0 in WR before `mem_ack`.
  - Expected: `mem_req`, `mem_lock` and `resp_valid` go to 0 asynchronously; after release the block is IDLE and the next tie goes to core 0.

Source files
------------

// File: rtl/amo_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : amo_alu / amo_arbiter
//  Purpose  : Two-core atomic memory operation sequencer. Round-robin grant,
//             locked read-modify-write on the shared data-memory port, and
//             return of the original memory word to the requesting core.
//  Revision : 1.0  initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  amo_alu : combinational modify step of the read-modify-write.
//  Opcode values match the AMO_* encodings used by taiga_types.
// ----------------------------------------------------------------------------
module amo_alu (
   input  logic [4:0]  op,
   input  logic [31:0] rs1_load,
   input  logic [31:0] rs2,
   output logic [31:0] result
);

   localparam logic [4:0] AMO_ADD  = 5'b00000;
   localparam logic [4:0] AMO_SWAP = 5'b00001;
   localparam logic [4:0] AMO_XOR  = 5'b00100;
   localparam logic [4:0] AMO_OR   = 5'b01000;
   localparam logic [4:0] AMO_AND  = 5'b01100;
   localparam logic [4:0] AMO_MIN  = 5'b10000;
   localparam logic [4:0] AMO_MAX  = 5'b10100;
   localparam logic [4:0] AMO_MINU = 5'b11000;
   localparam logic [4:0] AMO_MAXU = 5'b11100;

   logic signed_lt;
   logic unsigned_lt;

   // Shared comparators feed all four MIN/MAX variants; unknown opcodes yield 0
   always_comb begin
      signed_lt   = $signed(rs1_load) < $signed(rs2);
      unsigned_lt = rs1_load < rs2;
      result      = 32'h0;
      case (op)
         AMO_ADD:  result = rs1_load + rs2;
         AMO_SWAP: result = rs2;
         AMO_XOR:  result = rs1_load ^ rs2;
         AMO_OR:   result = rs1_load | rs2;
         AMO_AND:  result = rs1_load & rs2;
         AMO_MIN:  result = signed_lt   ? rs1_load : rs2;
         AMO_MAX:  result = signed_lt   ? rs2      : rs1_load;
         AMO_MINU: result = unsigned_lt ? rs1_load : rs2;
         AMO_MAXU: result = unsigned_lt ? rs2      : rs1_load;
         default:  result = 32'h0;
      endcase
   end

endmodule

// ----------------------------------------------------------------------------
//  amo_arbiter : top level. One AMO in flight at a time keeps every
//  read-modify-write atomic with respect to both cores.
// ----------------------------------------------------------------------------
module amo_arbiter (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [1:0][31:0] req_addr,
   input  logic [1:0][31:0] req_rs2,
   input  logic [1:0][4:0]  req_op,
   output logic [1:0]       resp_valid,
   input  logic [1:0]       resp_ready,
   output logic [31:0]      resp_data,
   output logic             mem_req,
   output logic             mem_we,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   input  logic             mem_ack,
   input  logic [31:0]      mem_rdata,
   output logic             mem_lock
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2,
      ST_RESP = 2'd3
   } state_e;

   state_e      state_q,      state_d;
   logic        last_grant_q, last_grant_d;
   logic        gnt_q,        gnt_d;
   logic [31:0] addr_q,       addr_d;
   logic [31:0] rs2_q,        rs2_d;
   logic [4:0]  op_q,         op_d;
   logic [31:0] old_val_q,    old_val_d;
   logic [31:0] new_val_q,    new_val_d;

   logic        arb_gnt;
   logic [31:0] alu_result;

   // Round-robin pick: a lone requester wins, a tie goes to the core not served last
   always_comb begin
      arb_gnt = 1'b0;
      case (req_valid)
         2'b10:   arb_gnt = 1'b1;
         2'b11:   arb_gnt = ~last_grant_q;
         default: arb_gnt = 1'b0;
      endcase
   end

   // Modify step works directly on the returning read data
   amo_alu u_amo_alu (
      .op       (op_q),
      .rs1_load (mem_rdata),
      .rs2      (rs2_q),
      .result   (alu_result)
   );

   // Next-state, request accept and operand capture
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      gnt_d        = gnt_q;
      addr_d       = addr_q;
      rs2_d        = rs2_q;
      op_d         = op_q;
      old_val_d    = old_val_q;
      new_val_d    = new_val_q;
      req_ready    = 2'b00;
      case (state_q)
         ST_IDLE: begin
            if (|req_valid) begin
               req_ready[arb_gnt] = 1'b1;
               addr_d             = req_addr[arb_gnt];
               rs2_d              = req_rs2[arb_gnt];
               op_d               = req_op[arb_gnt];
               gnt_d              = arb_gnt;
               last_grant_d       = arb_gnt;
               state_d            = ST_RD;
            end
         end
         ST_RD: begin
            if (mem_ack) begin
               old_val_d = mem_rdata;
               new_val_d = alu_result;
               state_d   = ST_WR;
            end
         end
         ST_WR: begin
            if (mem_ack) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (resp_ready[gnt_q]) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs decoded only from registered state/data, so memory inputs never reach them
   always_comb begin
      mem_req    = (state_q == ST_RD) || (state_q == ST_WR);
      mem_we     = (state_q == ST_WR);
      mem_lock   = mem_req;
      mem_addr   = mem_req ? addr_q : 32'h0;
      mem_wdata  = mem_we ? new_val_q : 32'h0;
      resp_valid = 2'b00;
      resp_data  = 32'h0;
      if (state_q == ST_RESP) begin
         resp_valid[gnt_q] = 1'b1;
         resp_data         = old_val_q;
      end
   end

   // State and datapath registers; last_grant resets to 1 so core 0 wins the first tie
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         last_grant_q <= 1'b1;
         gnt_q        <= 1'b0;
         addr_q       <= 32'h0;
         rs2_q        <= 32'h0;
         op_q         <= 5'h0;
         old_val_q    <= 32'h0;
         new_val_q    <= 32'h0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         gnt_q        <= gnt_d;
         addr_q       <= addr_d;
         rs2_q        <= rs2_d;
         op_q         <= op_d;
         old_val_q    <= old_val_d;
         new_val_q    <= new_val_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_amo_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_amo_arbiter
//  Purpose  : Self-checking bench for amo_arbiter. A transaction-level model
//             predicts grants, memory accesses and responses; a memory
//             responder with programmable wait states plays the memory.
//  Revision : 1.0  initial release
// ============================================================================
module tb_amo_arbiter;

   localparam logic [4:0] AMO_ADD  = 5'b00000;
   localparam logic [4:0] AMO_SWAP = 5'b00001;
   localparam logic [4:0] AMO_XOR  = 5'b00100;
   localparam logic [4:0] AMO_OR   = 5'b01000;
   localparam logic [4:0] AMO_AND  = 5'b01100;
   localparam logic [4:0] AMO_MIN  = 5'b10000;
   localparam logic [4:0] AMO_MAX  = 5'b10100;
   localparam logic [4:0] AMO_MINU = 5'b11000;
   localparam logic [4:0] AMO_MAXU = 5'b11100;

   logic             clk;
   logic             rst_n;
   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic [1:0][31:0] req_addr;
   logic [1:0][31:0] req_rs2;
   logic [1:0][4:0]  req_op;
   logic [1:0]       resp_valid;
   logic [1:0]       resp_ready;
   logic [31:0]      resp_data;
   logic             mem_req;
   logic             mem_we;
   logic [31:0]      mem_addr;
   logic [31:0]      mem_wdata;
   logic             mem_ack;
   logic [31:0]      mem_rdata;
   logic             mem_lock;

   typedef struct packed {
      logic        core;
      logic [31:0] data;
   } resp_t;

   resp_t       sb_q [$];
   logic [31:0] mem     [logic [31:0]];
   logic [31:0] ref_mem [logic [31:0]];
   logic [4:0]  ops_tab [9] = '{AMO_ADD, AMO_SWAP, AMO_XOR, AMO_OR, AMO_AND,
                                AMO_MIN, AMO_MAX, AMO_MINU, AMO_MAXU};

   int   n_vec = 0;
   int   n_err = 0;
   int   cyc   = 0;
   int   lock_cnt;
   int   done_cnt;
   int   acc_cnt [2];
   int   acc_cyc [2];
   int   resp_cyc[2];
   int   hs_cyc  [2];
   int   lat_rd, lat_wr;
   bit   lat_rand, hold_wr;
   // model of the in-flight transaction
   bit          pend, wr_done, resp_rec;
   logic        ref_last;
   int          phase;
   logic        pend_core;
   logic [31:0] pend_addr, pend_old, pend_new;

   amo_arbiter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .req_rs2    (req_rs2),
      .req_op     (req_op),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata),
      .mem_lock   (mem_lock)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] alu_ref(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      case (op)
         AMO_ADD:  return a + b;
         AMO_SWAP: return b;
         AMO_XOR:  return a ^ b;
         AMO_OR:   return a | b;
         AMO_AND:  return a & b;
         AMO_MIN:  return ($signed(a) < $signed(b)) ? a : b;
         AMO_MAX:  return ($signed(a) > $signed(b)) ? a : b;
         AMO_MINU: return (a < b) ? a : b;
         AMO_MAXU: return (a > b) ? a : b;
         default:  return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : 32'h0;
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
   endfunction

   task automatic preload(input logic [31:0] a, input logic [31:0] d);
      mem[a]     = d;
      ref_mem[a] = d;
   endtask

   // Memory responder: per-access wait states, garbage rdata when not acking
   task automatic mem_proc();
      int cnt;
      bit busy;
      busy = 1'b0;
      cnt  = 0;
      forever begin
         @(posedge clk);
         #1;
         mem_ack   = 1'b0;
         mem_rdata = $urandom;
         if (!rst_n || !mem_req) begin
            busy = 1'b0;
            if (lat_rand) mem_ack = 1'($urandom_range(0, 1));
            continue;
         end
         if (!busy) begin
            busy = 1'b1;
            cnt  = lat_rand ? int'($urandom_range(0, 3)) : (mem_we ? lat_wr : lat_rd);
         end
         if (cnt > 0) begin
            cnt--;
         end else if (!(mem_we && hold_wr)) begin
            mem_ack = 1'b1;
            busy    = 1'b0;
            if (mem_we) mem[mem_addr] = mem_wdata;
            else        mem_rdata = mem_rd(mem_addr);
         end
      end
   endtask

   // Monitor: checks grants, the locked access sequence and responses against the model
   task automatic monitor();
      logic [1:0]  exp_rr;
      logic        g;
      logic [31:0] a;
      bit          was_pend;
      resp_t       e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            if (pend && !wr_done) ref_mem[pend_addr] = pend_old;
            pend     = 1'b0;
            ref_last = 1'b1;
            sb_q.delete();
            continue;
         end
         if (mem_lock) lock_cnt++;
         was_pend = pend;
         if (pend) begin
            case (phase)
               0: begin
                  chk("rd_access", 64'({mem_req, mem_we, mem_lock, resp_valid, mem_addr}),
                      64'({1'b1, 1'b0, 1'b1, 2'b00, pend_addr}));
                  if (mem_ack) phase = 1;
               end
               1: begin
                  chk("wr_ctrl", 64'({mem_req, mem_we, mem_lock, resp_valid}),
                      64'({1'b1, 1'b1, 1'b1, 2'b00}));
                  chk("wr_data", {mem_addr, mem_wdata}, {pend_addr, pend_new});
                  if (mem_ack) begin
                     phase   = 2;
                     wr_done = 1'b1;
                  end
               end
               default: begin
                  if (!resp_rec) begin
                     resp_rec           = 1'b1;
                     resp_cyc[pend_core] = cyc;
                  end
                  if (sb_q.size() == 0) begin
                     chk("sb_empty", 64'(resp_valid), 64'(0));
                     pend = 1'b0;
                  end else begin
                     chk("resp_hold", 64'({mem_req, mem_lock, resp_valid, resp_data}),
                         64'({1'b0, 1'b0, 2'b01 << pend_core, sb_q[0].data}));
                     if (resp_ready[pend_core]) begin
                        e = sb_q.pop_front();
                        chk("resp_data", 64'({resp_valid[e.core], resp_data}),
                            64'({1'b1, e.data}));
                        hs_cyc[pend_core] = cyc;
                        pend = 1'b0;
                     end
                  end
               end
            endcase
         end else begin
            chk("idle_out", 64'({mem_req, mem_we, mem_lock, resp_valid}), 64'(0));
         end
         exp_rr = 2'b00;
         g      = 1'b0;
         if (!was_pend && req_valid != 2'b00) begin
            g         = (req_valid == 2'b11) ? ~ref_last : req_valid[1];
            exp_rr[g] = 1'b1;
         end
         chk("grant", 64'(req_ready), 64'(exp_rr));
         if (exp_rr != 2'b00 && req_ready == exp_rr) begin
            a         = req_addr[g];
            pend_old  = ref_rd(a);
            pend_new  = alu_ref(req_op[g], pend_old, req_rs2[g]);
            ref_mem[a] = pend_new;
            pend      = 1'b1;
            phase     = 0;
            wr_done   = 1'b0;
            resp_rec  = 1'b0;
            pend_core = g;
            pend_addr = a;
            ref_last  = g;
            sb_q.push_back(resp_t'{core: g, data: pend_old});
            acc_cyc[g] = cyc;
            acc_cnt[g]++;
         end
      end
   endtask

   // Raise a request, hold it until accepted, then scramble the fields
   task automatic issue(input int c, input logic [31:0] a, input logic [31:0] d,
                        input logic [4:0] op);
      int n;
      int k;
      n           = acc_cnt[c];
      req_addr[c] = a;
      req_rs2[c]  = d;
      req_op[c]   = op;
      req_valid[c] = 1'b1;
      k = 0;
      while (acc_cnt[c] == n && k < 400) begin
         @(posedge clk);
         k++;
      end
      #1;
      chk("accept_timeout", 64'(acc_cnt[c] != n), 64'(1));
      req_valid[c] = 1'b0;
      req_addr[c]  = $urandom;
      req_rs2[c]   = $urandom;
      req_op[c]    = 5'($urandom);
   endtask

   task automatic wait_done();
      int k;
      k = 0;
      while ((pend || req_valid != 2'b00) && k < 500) begin
         @(posedge clk);
         k++;
      end
      #1;
      chk("drain_timeout", 64'(k < 500), 64'(1));
   endtask

   task automatic rand_client(input int c);
      logic [4:0] op;
      for (int i = 0; i < 30; i++) begin
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
         end
         op = ($urandom_range(0, 7) == 0) ? 5'($urandom) : ops_tab[$urandom_range(0, 8)];
         issue(c, 32'h400 + 32'(4 * $urandom_range(0, 3)), $urandom, op);
      end
      done_cnt++;
   endtask

   task automatic rr_random();
      while (done_cnt < 2) begin
         @(posedge clk);
         #1;
         resp_ready = 2'($urandom);
      end
      resp_ready = 2'b11;
   endtask

   initial begin : main
      logic [4:0]  sgn_op  [4];
      logic [31:0] sgn_exp [4];
      int          k;
      sgn_op  = '{AMO_MIN, AMO_MINU, AMO_MAX, AMO_MAXU};
      sgn_exp = '{32'hFFFF_FFFF, 32'h1, 32'h1, 32'hFFFF_FFFF};
      rst_n      = 1'b0;
      req_valid  = 2'b00;
      req_addr   = '0;
      req_rs2    = '0;
      req_op     = '0;
      resp_ready = 2'b11;
      mem_ack    = 1'b0;
      mem_rdata  = 32'h0;
      lat_rd = 0; lat_wr = 0; lat_rand = 1'b0; hold_wr = 1'b0;
      pend = 1'b0; ref_last = 1'b1; lock_cnt = 0; done_cnt = 0;
      acc_cnt = '{0, 0};
      fork
         mem_proc();
         monitor();
      join_none

      // reset values
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req_ready",  64'(req_ready),  64'(0));
      chk("rst_resp_valid", 64'(resp_valid), 64'(0));
      chk("rst_mem_ctrl",   64'({mem_req, mem_we, mem_lock}), 64'(0));
      chk("rst_mem_addr",   64'(mem_addr),   64'(0));
      chk("rst_mem_wdata",  64'(mem_wdata),  64'(0));
      chk("rst_resp_data",  64'(resp_data),  64'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) begin @(posedge clk); #1; end

      // two rounds of simultaneous requests: core 0 first both times
      for (int r = 0; r < 2; r++) begin
         fork
            issue(0, 32'h700 + 32'(r * 8), 32'h11, AMO_ADD);
            issue(1, 32'h704 + 32'(r * 8), 32'h22, AMO_OR);
         join
         wait_done();
         chk("tie_order", 64'(acc_cyc[0] < acc_cyc[1]), 64'(1));
      end

      // single ADD, zero-wait memory
      preload(32'h100, 32'h0000_000A);
      lock_cnt = 0;
      issue(0, 32'h100, 32'h5, AMO_ADD);
      wait_done();
      chk("add_mem",  64'(mem_rd(32'h100)), 64'(32'h0F));
      chk("add_lat",  64'(resp_cyc[0] - acc_cyc[0]), 64'(3));
      chk("add_lock", 64'(lock_cnt), 64'(2));

      // signed vs unsigned compares
      for (int i = 0; i < 4; i++) begin
         preload(32'h200, 32'hFFFF_FFFF);
         issue(1, 32'h200, 32'h1, sgn_op[i]);
         wait_done();
         chk("minmax_mem", 64'(mem_rd(32'h200)), 64'(sgn_exp[i]));
      end

      // memory wait states: 3 on read, 2 on write
      lat_rd = 3; lat_wr = 2;
      preload(32'h600, 32'h0000_F0F0);
      issue(0, 32'h600, 32'h0000_00FF, AMO_XOR);
      wait_done();
      chk("wait_lat", 64'(resp_cyc[0] - acc_cyc[0]), 64'(8));
      chk("wait_mem", 64'(mem_rd(32'h600)), 64'(32'h0000_F00F));
      lat_rd = 0; lat_wr = 0;

      // response backpressure with core 1 waiting
      preload(32'h500, 32'h0000_0042);
      resp_ready = 2'b10;
      fork
         issue(0, 32'h500, 32'h7, AMO_SWAP);
         begin
            repeat (2) begin @(posedge clk); #1; end
            issue(1, 32'h504, 32'h3, AMO_ADD);
         end
         begin
            k = 0;
            while (!resp_valid[0] && k < 50) begin @(negedge clk); k++; end
            repeat (4) @(posedge clk);
            #1;
            resp_ready = 2'b11;
         end
      join
      wait_done();
      chk("bp_held", 64'(hs_cyc[0] - resp_cyc[0]), 64'(4));
      chk("bp_next_accept", 64'(acc_cyc[1]), 64'(hs_cyc[0] + 1));

      // randomized traffic with random wait states and backpressure
      for (int i = 0; i < 4; i++) preload(32'h400 + 32'(4 * i), $urandom);
      lat_rand = 1'b1;
      fork
         rand_client(0);
         rand_client(1);
         rr_random();
      join
      wait_done();
      lat_rand = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      for (int i = 0; i < 4; i++)
         chk("rand_mem", 64'(mem_rd(32'h400 + 32'(4 * i))), 64'(ref_rd(32'h400 + 32'(4 * i))));

      // asynchronous reset while waiting for the write ack
      preload(32'h300, 32'h0000_1234);
      hold_wr = 1'b1;
      issue(0, 32'h300, 32'h1, AMO_ADD);
      k = 0;
      while (!(mem_req && mem_we) && k < 20) begin @(negedge clk); k++; end
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_rst", 64'({mem_req, mem_we, mem_lock, resp_valid}), 64'(0));
      @(posedge clk);
      #1;
      rst_n   = 1'b1;
      hold_wr = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_mem_untouched", 64'(mem_rd(32'h300)), 64'(32'h0000_1234));
      fork
         issue(0, 32'h310, 32'h1, AMO_ADD);
         issue(1, 32'h314, 32'h2, AMO_ADD);
      join
      wait_done();
      chk("rst_tie_order", 64'(acc_cyc[0] < acc_cyc[1]), 64'(1));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
